// File: rtl/poly_tone_sequencer.sv
// rtl/poly_tone_sequencer.sv - multi-voice square-wave note sequencer with in-order note FIFO
module poly_tone_sequencer #(
  parameter int NUM_VOICES = 2,
  parameter int DEPTH      = 8,
  parameter int PERIOD_W   = 16,
  parameter int DUR_W      = 12,
  localparam int VW        = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           ticks_per_milli,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VW-1:0]         in_voice,
  input  logic [PERIOD_W-1:0]   in_half_period,
  input  logic [DUR_W-1:0]      in_duration,
  output logic [NUM_VOICES-1:0] sound,
  output logic                  sound_mix,
  output logic [7:0]            led,
  output logic                  busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = VW + PERIOD_W + DUR_W;

  typedef enum logic {
    V_IDLE = 1'b0,
    V_PLAY = 1'b1
  } voice_state_t;

  // ---------------------------------------------------------------- ms tick
  logic [15:0] tick_cnt;
  logic [15:0] tick_last;
  logic        ms_tick;

  // Terminal count of the tick divider; >= keeps a shrinking divisor from running away
  always_comb begin
    tick_last = (ticks_per_milli > 16'd1) ? (ticks_per_milli - 16'd1) : 16'd0;
    ms_tick   = (tick_cnt >= tick_last);
  end

  // Millisecond divider counter, restarted by reset and flush
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      tick_cnt <= '0;
    end else if (ms_tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------- note FIFO
  logic [EW-1:0]         mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  push;
  logic                  pop;
  logic                  load_en;
  logic                  fifo_nonempty;
  logic [EW-1:0]         head;
  logic [VW-1:0]         head_voice;
  logic [PERIOD_W-1:0]   head_hp;
  logic [DUR_W-1:0]      head_dur;
  logic                  head_in_range;
  logic [NUM_VOICES-1:0] voice_busy;
  logic [3:0]            busy4;

  // Push/pop qualification; a busy target voice blocks the head, out-of-range heads are dropped
  always_comb begin
    in_ready      = (level != LW'(DEPTH));
    fifo_nonempty = (level != '0);
    head          = mem[rd_ptr];
    head_voice    = head[EW-1 -: VW];
    head_hp       = head[DUR_W +: PERIOD_W];
    head_dur      = head[DUR_W-1:0];
    head_in_range = ({1'b0, head_voice} < (VW+1)'(NUM_VOICES));
    busy4         = 4'(voice_busy);
    push          = in_valid && in_ready && !flush && !rst;
    pop           = fifo_nonempty && !flush && !rst && (!head_in_range || !busy4[head_voice]);
    load_en       = pop && head_in_range;
  end

  // FIFO storage; no reset needed since level/pointers qualify every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_voice, in_half_period, in_duration};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------- voices
  voice_state_t [NUM_VOICES-1:0]               state_q;
  voice_state_t [NUM_VOICES-1:0]               state_d;
  logic [NUM_VOICES-1:0][DUR_W-1:0]            rem_q;
  logic [NUM_VOICES-1:0][PERIOD_W-1:0]         hp_q;
  logic [NUM_VOICES-1:0][PERIOD_W-1:0]         phase_q;
  logic [NUM_VOICES-1:0]                       snd_q;
  logic [NUM_VOICES-1:0]                       load_v;

  // Voice next-state: start on dispatch, stop when the remaining duration runs out
  always_comb begin
    state_d    = state_q;
    load_v     = '0;
    voice_busy = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      load_v[v]     = load_en && (head_voice == VW'(v));
      voice_busy[v] = (state_q[v] == V_PLAY);
      case (state_q[v])
        V_IDLE: begin
          if (load_v[v]) state_d[v] = V_PLAY;
        end
        V_PLAY: begin
          if (rem_q[v] == '0) begin
            state_d[v] = V_IDLE;
          end else if (ms_tick && (rem_q[v] == DUR_W'(1))) begin
            state_d[v] = V_IDLE;
          end
        end
        default: state_d[v] = V_IDLE;
      endcase
    end
  end

  // Voice state register
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= {NUM_VOICES{V_IDLE}};
    end else begin
      state_q <= state_d;
    end
  end

  // Per-voice duration countdown and square-wave phase generator
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rst || flush) begin
        rem_q[v]   <= '0;
        hp_q[v]    <= '0;
        phase_q[v] <= '0;
        snd_q[v]   <= 1'b0;
      end else if (load_v[v]) begin
        rem_q[v]   <= head_dur;
        hp_q[v]    <= head_hp;
        phase_q[v] <= '0;
        snd_q[v]   <= 1'b0;
      end else if (state_q[v] == V_PLAY) begin
        if (state_d[v] == V_IDLE) begin
          phase_q[v] <= '0;
          snd_q[v]   <= 1'b0;
        end else begin
          if (ms_tick) rem_q[v] <= rem_q[v] - DUR_W'(1);
          if (hp_q[v] == '0) begin
            snd_q[v] <= 1'b0;
          end else if (phase_q[v] == (hp_q[v] - PERIOD_W'(1))) begin
            phase_q[v] <= '0;
            snd_q[v]   <= ~snd_q[v];
          end else begin
            phase_q[v] <= phase_q[v] + PERIOD_W'(1);
          end
        end
      end
    end
  end

  // Status outputs derived directly from registered state
  always_comb begin
    sound     = snd_q;
    sound_mix = ^snd_q;
    led       = {((32'(level) > 32'd15) ? 4'hF : 4'(level)), busy4};
    busy      = fifo_nonempty || (|voice_busy);
  end

endmodule
